// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns core byte/half/word accesses into aligned 32-bit memory
// transactions, with sign/zero extension on loads and read-modify-write for sub-word stores.
module lsu_mem_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_req_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_LOAD_WAIT = 2'b01,
        S_RMW_MERGE = 2'b10
    } state_t;

    state_t      r_state;
    logic [29:0] r_word_addr;
    logic [1:0]  r_offset;
    logic [2:0]  r_size;
    logic [31:0] r_wd;

    logic        w_illegal;
    logic        w_misaligned;
    logic        w_bad;
    logic        w_accept;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    // Loads allow 000/001/010/100/101; stores allow only 000/001/010.
    always_comb begin
        if (core_we_i) begin
            w_illegal = (core_size_i >= 3'b011);
        end else begin
            w_illegal = (core_size_i == 3'b011) || (core_size_i == 3'b110) ||
                        (core_size_i == 3'b111);
        end
        w_misaligned = ((core_size_i[1:0] == 2'b01) && core_addr_i[0]) ||
                       ((core_size_i[1:0] == 2'b10) && (core_addr_i[1:0] != 2'b00));
        w_bad    = w_illegal || w_misaligned;
        w_accept = (r_state == S_IDLE) && core_req_i && !w_bad;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_word_addr <= '0;
            r_offset    <= '0;
            r_size      <= '0;
            r_wd        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_word_addr <= core_addr_i[31:2];
                        r_offset    <= core_addr_i[1:0];
                        r_size      <= core_size_i;
                        r_wd        <= core_wd_i;
                        if (!core_we_i) begin
                            r_state <= S_LOAD_WAIT;
                        end else if (core_size_i != 3'b010) begin
                            r_state <= S_RMW_MERGE;
                        end
                    end
                end
                S_LOAD_WAIT: r_state <= S_IDLE;
                S_RMW_MERGE: r_state <= S_IDLE;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    // Lane extraction from the registered memory word, little-endian.
    always_comb begin
        case (r_offset)
            2'b00:   w_byte = mem_rd_i[7:0];
            2'b01:   w_byte = mem_rd_i[15:8];
            2'b10:   w_byte = mem_rd_i[23:16];
            default: w_byte = mem_rd_i[31:24];
        endcase
        w_half = r_offset[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

        case (r_size)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = mem_rd_i;
        endcase
    end

    // Replace only the targeted lane of the word just read back.
    always_comb begin
        w_merge_data = mem_rd_i;
        if (r_size[1:0] == 2'b00) begin
            case (r_offset)
                2'b00:   w_merge_data[7:0]   = r_wd[7:0];
                2'b01:   w_merge_data[15:8]  = r_wd[7:0];
                2'b10:   w_merge_data[23:16] = r_wd[7:0];
                default: w_merge_data[31:24] = r_wd[7:0];
            endcase
        end else if (r_offset[1]) begin
            w_merge_data[31:16] = r_wd[15:0];
        end else begin
            w_merge_data[15:0] = r_wd[15:0];
        end
    end

    always_comb begin
        core_rd_o        = '0;
        core_stall_req_o = 1'b0;
        err_o            = 1'b0;
        mem_req_o        = 1'b0;
        mem_we_o         = 1'b0;
        mem_addr_o       = '0;
        mem_wd_o         = '0;
        if (!rst_i) begin
            case (r_state)
                S_IDLE: begin
                    mem_addr_o = {core_addr_i[31:2], 2'b00};
                    if (core_req_i) begin
                        if (w_bad) begin
                            err_o = 1'b1;
                        end else if (core_we_i && (core_size_i == 3'b010)) begin
                            mem_req_o = 1'b1;
                            mem_we_o  = 1'b1;
                            mem_wd_o  = core_wd_i;
                        end else begin
                            mem_req_o        = 1'b1;
                            core_stall_req_o = 1'b1;
                        end
                    end
                end
                S_LOAD_WAIT: begin
                    mem_addr_o = {r_word_addr, 2'b00};
                    core_rd_o  = w_load_data;
                end
                S_RMW_MERGE: begin
                    mem_addr_o = {r_word_addr, 2'b00};
                    mem_req_o  = 1'b1;
                    mem_we_o   = 1'b1;
                    mem_wd_o   = w_merge_data;
                end
                default: begin
                    mem_addr_o = '0;
                end
            endcase
        end
    end

endmodule
